// File: rtl/rpn_lan_to_network_bridge_arbiter.sv
// Packet-level 3:1 AXIS arbiter toward the network bridge, with a 2-entry output register stage.
// Optional RPN_LAN_ARB_STRICT_PRIO_EN selects fixed priority s0 > s1 > s2 instead of round-robin.
module rpn_lan_to_network_bridge_arbiter #(
  parameter int AXIS_DATA_WIDTH        = 64,
  parameter int AXIS_KEEP_WIDTH        = 8,
  parameter int AXIS_TO_NB_TDEST_WIDTH = 16,
  parameter int AXIS_TO_NB_TUSER_WIDTH = 16
) (
  input  logic                              i_clk,
  input  logic                              i_ap_rst,

  input  logic                              from_rpn_LAN_RX_tvalid,
  output logic                              from_rpn_LAN_RX_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]        from_rpn_LAN_RX_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]        from_rpn_LAN_RX_tkeep,
  input  logic [AXIS_TO_NB_TDEST_WIDTH-1:0] from_rpn_LAN_RX_tid,
  input  logic [AXIS_TO_NB_TDEST_WIDTH-1:0] from_rpn_LAN_RX_tdest,
  input  logic [AXIS_TO_NB_TUSER_WIDTH-1:0] from_rpn_LAN_RX_tuser,
  input  logic                              from_rpn_LAN_RX_tlast,

  input  logic                              from_rpn_LAN_TX_tvalid,
  output logic                              from_rpn_LAN_TX_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]        from_rpn_LAN_TX_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]        from_rpn_LAN_TX_tkeep,
  input  logic [AXIS_TO_NB_TDEST_WIDTH-1:0] from_rpn_LAN_TX_tid,
  input  logic [AXIS_TO_NB_TDEST_WIDTH-1:0] from_rpn_LAN_TX_tdest,
  input  logic [AXIS_TO_NB_TUSER_WIDTH-1:0] from_rpn_LAN_TX_tuser,
  input  logic                              from_rpn_LAN_TX_tlast,

  input  logic                              from_rpn_LAN_seq_num_initializer_tvalid,
  output logic                              from_rpn_LAN_seq_num_initializer_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]        from_rpn_LAN_seq_num_initializer_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]        from_rpn_LAN_seq_num_initializer_tkeep,
  input  logic [AXIS_TO_NB_TDEST_WIDTH-1:0] from_rpn_LAN_seq_num_initializer_tid,
  input  logic [AXIS_TO_NB_TDEST_WIDTH-1:0] from_rpn_LAN_seq_num_initializer_tdest,
  input  logic [AXIS_TO_NB_TUSER_WIDTH-1:0] from_rpn_LAN_seq_num_initializer_tuser,
  input  logic                              from_rpn_LAN_seq_num_initializer_tlast,

  output logic                              to_network_bridge_tvalid,
  input  logic                              to_network_bridge_tready,
  output logic [AXIS_DATA_WIDTH-1:0]        to_network_bridge_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]        to_network_bridge_tkeep,
  output logic [AXIS_TO_NB_TDEST_WIDTH-1:0] to_network_bridge_tid,
  output logic [AXIS_TO_NB_TDEST_WIDTH-1:0] to_network_bridge_tdest,
  output logic [AXIS_TO_NB_TUSER_WIDTH-1:0] to_network_bridge_tuser,
  output logic                              to_network_bridge_tlast,

  output logic [2:0]                        o_grant
);

  localparam int BW = AXIS_DATA_WIDTH + AXIS_KEEP_WIDTH + 2 * AXIS_TO_NB_TDEST_WIDTH
                    + AXIS_TO_NB_TUSER_WIDTH + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PASS = 1'b1;

  logic [0:0]    state;
  logic [2:0]    grant;
  logic [1:0]    last_grant;
  logic [1:0]    count;
  logic [BW-1:0] head;
  logic [BW-1:0] tail;

  logic [2:0]    req;
  logic [BW-1:0] beat0, beat1, beat2;
  logic [BW-1:0] sel_beat;
  logic          sel_valid;
  logic          accept_ready;
  logic          push;
  logic          pop;
  logic [1:0]    next_idx;

  assign req   = {from_rpn_LAN_seq_num_initializer_tvalid, from_rpn_LAN_TX_tvalid,
                  from_rpn_LAN_RX_tvalid};
  assign beat0 = {from_rpn_LAN_RX_tdata, from_rpn_LAN_RX_tkeep, from_rpn_LAN_RX_tid,
                  from_rpn_LAN_RX_tdest, from_rpn_LAN_RX_tuser, from_rpn_LAN_RX_tlast};
  assign beat1 = {from_rpn_LAN_TX_tdata, from_rpn_LAN_TX_tkeep, from_rpn_LAN_TX_tid,
                  from_rpn_LAN_TX_tdest, from_rpn_LAN_TX_tuser, from_rpn_LAN_TX_tlast};
  assign beat2 = {from_rpn_LAN_seq_num_initializer_tdata, from_rpn_LAN_seq_num_initializer_tkeep,
                  from_rpn_LAN_seq_num_initializer_tid, from_rpn_LAN_seq_num_initializer_tdest,
                  from_rpn_LAN_seq_num_initializer_tuser, from_rpn_LAN_seq_num_initializer_tlast};

  always_comb begin
    sel_beat  = '0;
    sel_valid = 1'b0;
    unique case (grant)
      3'b001: begin sel_beat = beat0; sel_valid = req[0]; end
      3'b010: begin sel_beat = beat1; sel_valid = req[1]; end
      3'b100: begin sel_beat = beat2; sel_valid = req[2]; end
      default: ;
    endcase
  end

  // Ready depends only on registered state, so bridge tready never reaches a source combinationally.
  assign accept_ready = (state == PASS) && (count != 2'd2);
  assign push         = accept_ready && sel_valid;
  assign pop          = (count != 2'd0) && to_network_bridge_tready;

  assign from_rpn_LAN_RX_tready                  = grant[0] && accept_ready;
  assign from_rpn_LAN_TX_tready                  = grant[1] && accept_ready;
  assign from_rpn_LAN_seq_num_initializer_tready = grant[2] && accept_ready;

  always_comb begin
    next_idx = 2'd0;
`ifdef RPN_LAN_ARB_STRICT_PRIO_EN
    if (req[0])      next_idx = 2'd0;
    else if (req[1]) next_idx = 2'd1;
    else if (req[2]) next_idx = 2'd2;
`else
    begin
      logic       found;
      logic [1:0] cand;
      found = 1'b0;
      for (int unsigned k = 0; k < 3; k++) begin
        cand = 2'((32'(last_grant) + 32'd1 + k) % 32'd3);
        if (!found && req[cand]) begin
          next_idx = cand;
          found    = 1'b1;
        end
      end
    end
`endif
  end

  always_ff @(posedge i_clk or posedge i_ap_rst) begin
    if (i_ap_rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= 2'd2;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant      <= 3'b001 << next_idx;
            last_grant <= next_idx;
            state      <= PASS;
          end
        end
        default: begin
          if (push && sel_beat[0]) begin
            grant <= '0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_ap_rst) begin
    if (i_ap_rst) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            head  <= sel_beat;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head <= sel_beat;
          end else if (push) begin
            tail  <= sel_beat;
            count <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head  <= tail;
            count <= 2'd1;
          end
        end
      endcase
    end
  end

  assign to_network_bridge_tvalid = (count != 2'd0);
  assign {to_network_bridge_tdata, to_network_bridge_tkeep, to_network_bridge_tid,
          to_network_bridge_tdest, to_network_bridge_tuser, to_network_bridge_tlast} = head;
  assign o_grant = grant;

endmodule

// File: tb/tb_rpn_lan_to_network_bridge_arbiter.sv
// Self-checking bench: cycle table for a basic packet, then directed multi-cycle sequences.
module tb_rpn_lan_to_network_bridge_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  v = '0;
  logic [2:0]  rdy;
  logic [63:0] dd [3];
  logic [2:0]  ll = '0;
  logic        br = 1'b1;
  logic        ov, ol;
  logic [63:0] od;
  logic [7:0]  okeep;
  logic [15:0] oid, odst, ous;
  logic [2:0]  og;

  always #5 clk = ~clk;

  rpn_lan_to_network_bridge_arbiter dut (
    .i_clk(clk), .i_ap_rst(rst),
    .from_rpn_LAN_RX_tvalid(v[0]), .from_rpn_LAN_RX_tready(rdy[0]),
    .from_rpn_LAN_RX_tdata(dd[0]), .from_rpn_LAN_RX_tkeep(8'hFF),
    .from_rpn_LAN_RX_tid(16'h0000), .from_rpn_LAN_RX_tdest(16'h0000),
    .from_rpn_LAN_RX_tuser(16'h0010), .from_rpn_LAN_RX_tlast(ll[0]),
    .from_rpn_LAN_TX_tvalid(v[1]), .from_rpn_LAN_TX_tready(rdy[1]),
    .from_rpn_LAN_TX_tdata(dd[1]), .from_rpn_LAN_TX_tkeep(8'hFF),
    .from_rpn_LAN_TX_tid(16'h0001), .from_rpn_LAN_TX_tdest(16'h0001),
    .from_rpn_LAN_TX_tuser(16'h0011), .from_rpn_LAN_TX_tlast(ll[1]),
    .from_rpn_LAN_seq_num_initializer_tvalid(v[2]), .from_rpn_LAN_seq_num_initializer_tready(rdy[2]),
    .from_rpn_LAN_seq_num_initializer_tdata(dd[2]), .from_rpn_LAN_seq_num_initializer_tkeep(8'hFF),
    .from_rpn_LAN_seq_num_initializer_tid(16'h0002), .from_rpn_LAN_seq_num_initializer_tdest(16'h0002),
    .from_rpn_LAN_seq_num_initializer_tuser(16'h0012), .from_rpn_LAN_seq_num_initializer_tlast(ll[2]),
    .to_network_bridge_tvalid(ov), .to_network_bridge_tready(br),
    .to_network_bridge_tdata(od), .to_network_bridge_tkeep(okeep),
    .to_network_bridge_tid(oid), .to_network_bridge_tdest(odst),
    .to_network_bridge_tuser(ous), .to_network_bridge_tlast(ol),
    .o_grant(og)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]  v;
    logic [63:0] d;
    logic        l;
    logic [2:0]  eg;
    logic        ev;
    logic [63:0] ed;
    logic        el;
    logic [2:0]  erdy;
  } vec_t;
  vec_t tv [6];

  // Source/sink model state
  int          npk [3];
  int          len [3];
  int          idx [3];
  int          pkt [3];
  int          acc_cnt [3];
  logic [2:0]  hold;
  logic [63:0] sink_d [$];
  logic        sink_l [$];
  logic [2:0]  glog [$];
  logic [2:0]  prev_grant;
  int          cyc;
  int          t_last0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  function automatic logic [63:0] mk(input int s, input int p, input int b);
    return (64'(s) << 16) | (64'(p) << 8) | 64'(b);
  endfunction

  task automatic drive();
    for (int i = 0; i < 3; i++) begin
      v[i]  = (npk[i] > 0) && !hold[i];
      dd[i] = mk(i, pkt[i], idx[i]);
      ll[i] = (idx[i] == len[i] - 1);
    end
  endtask

  task automatic tick();
    logic [2:0] acc;
    logic       was_last0;
    acc = v & rdy;
    was_last0 = ll[0];
    if (ov && br) begin
      sink_d.push_back(od);
      sink_l.push_back(ol);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (acc[i]) begin
        acc_cnt[i]++;
        if (idx[i] == len[i] - 1) begin
          idx[i] = 0;
          npk[i]--;
          pkt[i]++;
        end else begin
          idx[i]++;
        end
      end
    end
    if (acc[0] && was_last0) t_last0 = cyc;
    if (og != 3'b000 && og != prev_grant) glog.push_back(og);
    prev_grant = og;
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    br  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      npk[i] = 0; len[i] = 1; idx[i] = 0; pkt[i] = 0; acc_cnt[i] = 0;
    end
    hold = '0;
    sink_d.delete();
    sink_l.delete();
    glog.delete();
    prev_grant = '0;
    t_last0 = -1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    logic [2:0] exp_g [6];
    int n;

    // Basic s1 3-beat packet, one row per cycle: check outputs, then apply that cycle's inputs.
    tv[0] = '{3'b010, 64'hA1, 1'b0, 3'b000, 1'b0, 64'h0,  1'b0, 3'b000};
    tv[1] = '{3'b010, 64'hA1, 1'b0, 3'b010, 1'b0, 64'h0,  1'b0, 3'b010};
    tv[2] = '{3'b010, 64'hA2, 1'b0, 3'b010, 1'b1, 64'hA1, 1'b0, 3'b010};
    tv[3] = '{3'b010, 64'hA3, 1'b1, 3'b010, 1'b1, 64'hA2, 1'b0, 3'b010};
    tv[4] = '{3'b000, 64'h0,  1'b0, 3'b000, 1'b1, 64'hA3, 1'b1, 3'b000};
    tv[5] = '{3'b000, 64'h0,  1'b0, 3'b000, 1'b0, 64'h0,  1'b0, 3'b000};

    for (int i = 0; i < 3; i++) dd[i] = '0;
    @(posedge clk);
    #1;
    chk("reset_tvalid", 64'(ov), 64'(0));
    chk("reset_tdata", od, 64'h0);
    chk("reset_tuser_tdest", 64'({ous, odst, oid}), 64'h0);
    chk("reset_grant", 64'(og), 64'(0));
    chk("reset_tready", 64'(rdy), 64'(0));

    do_reset();
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("tbl%0d_grant", k), 64'(og), 64'(tv[k].eg));
      chk($sformatf("tbl%0d_tvalid", k), 64'(ov), 64'(tv[k].ev));
      chk($sformatf("tbl%0d_tready", k), 64'(rdy), 64'(tv[k].erdy));
      if (tv[k].ev) begin
        chk($sformatf("tbl%0d_tdata", k), od, tv[k].ed);
        chk($sformatf("tbl%0d_tlast", k), 64'(ol), 64'(tv[k].el));
        chk($sformatf("tbl%0d_tdest", k), 64'(odst), 64'h1);
      end
      v = tv[k].v;
      for (int i = 0; i < 3; i++) dd[i] = tv[k].d;
      ll = {3{tv[k].l}};
      @(posedge clk);
      #1;
    end

    // All sources continuously valid with single-beat packets.
    do_reset();
    for (int i = 0; i < 3; i++) npk[i] = 10;
    drive();
    n = 0;
    while (glog.size() < 6 && n < 60) begin tick(); n++; end
    if (glog.size() < 6) timeout("rr_grants");
    else begin
`ifdef RPN_LAN_ARB_STRICT_PRIO_EN
      exp_g = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`else
      exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`endif
      for (int k = 0; k < 6; k++) chk($sformatf("grant_order%0d", k), 64'(glog[k]), 64'(exp_g[k]));
    end

    // s0 4-beat packet with s2 waiting.
    do_reset();
    len[0] = 4; npk[0] = 1;
    npk[2] = 1;
    drive();
    n = 0;
    while (og != 3'b100 && n < 40) begin
      tick(); n++;
      if (og == 3'b001) chk("hold_s2_tready", 64'(rdy[2]), 64'(0));
    end
    if (og != 3'b100) timeout("s2_grant");
    else chk("s2_grant_cycle", 64'(cyc), 64'(t_last0 + 1));
    n = 0;
    while (sink_d.size() < 5 && n < 40) begin tick(); n++; end
    if (sink_d.size() < 5) timeout("hold_sink");
    else begin
      for (int k = 0; k < 4; k++) chk($sformatf("hold_s0_beat%0d", k), sink_d[k], mk(0, 0, k));
      chk("hold_s2_beat", sink_d[4], mk(2, 0, 0));
    end

    // Bridge backpressure on a 5-beat packet.
    do_reset();
    br = 1'b0;
    len[0] = 5; npk[0] = 1;
    drive();
    repeat (10) tick();
    chk("bp_accepted", 64'(acc_cnt[0]), 64'(2));
    chk("bp_src_tready", 64'(rdy[0]), 64'(0));
    chk("bp_out_tvalid", 64'(ov), 64'(1));
    br = 1'b1;
    n = 0;
    while ((sink_d.size() < 5 || ov) && n < 40) begin tick(); n++; end
    if (sink_d.size() < 5) timeout("bp_sink");
    else begin
      chk("bp_count", 64'(sink_d.size()), 64'(5));
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("bp_beat%0d", k), sink_d[k], mk(0, 0, k));
        chk($sformatf("bp_last%0d", k), 64'(sink_l[k]), 64'(k == 4));
      end
    end

    // Asynchronous reset after beat 2 of a 4-beat packet.
    do_reset();
    len[0] = 4; npk[0] = 1;
    drive();
    n = 0;
    while (acc_cnt[0] < 2 && n < 20) begin tick(); n++; end
    if (acc_cnt[0] < 2) timeout("rst_prep");
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_tvalid", 64'(ov), 64'(0));
    chk("rst_async_grant", 64'(og), 64'(0));
    chk("rst_async_tready", 64'(rdy), 64'(0));
    do_reset();
    for (int i = 0; i < 3; i++) npk[i] = 1;
    drive();
    n = 0;
    while (glog.size() < 1 && n < 20) begin tick(); n++; end
    if (glog.size() < 1) timeout("rst_regrant");
    else chk("rst_first_grant", 64'(glog[0]), 64'(3'b001));

    // Granted s1 stalls mid-packet while s0 is valid.
    do_reset();
    len[1] = 4; npk[1] = 1;
    drive();
    n = 0;
    while (og != 3'b010 && n < 20) begin tick(); n++; end
    if (og != 3'b010) timeout("stall_grant");
    npk[0] = 1;
    drive();
    n = 0;
    while (acc_cnt[1] < 2 && n < 20) begin tick(); n++; end
    hold[1] = 1'b1;
    drive();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall%0d_grant", k), 64'(og), 64'(3'b010));
      chk($sformatf("stall%0d_s0_tready", k), 64'(rdy[0]), 64'(0));
    end
    hold[1] = 1'b0;
    drive();
    n = 0;
    while ((sink_d.size() < 5 || ov) && n < 40) begin tick(); n++; end
    if (sink_d.size() < 5) timeout("stall_sink");
    else begin
      chk("stall_count", 64'(sink_d.size()), 64'(5));
      for (int k = 0; k < 4; k++) chk($sformatf("stall_s1_beat%0d", k), sink_d[k], mk(1, 0, k));
      chk("stall_s0_beat", sink_d[4], mk(0, 0, 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rpn_lan_to_network_bridge_arbiter.md
# rpn_lan_to_network_bridge_arbiter

Packet-level arbiter that shares the single AXIS path toward the network bridge among the three reliability-layer producers: RPN LAN RX (ACKs), RPN LAN TX (PUB / SEQ_NUM_CHECK), and the RPN LAN sequence-number initializer (SEQ_NUM requests). It is the egress counterpart of the from-network-bridge splitter. It grants one source per packet, holds the grant until tlast, and buffers output in a 2-entry register stage so the bridge's tready has no combinational path to any source.

## Interface
Parameters:
- AXIS_DATA_WIDTH, 64, tdata width.
- AXIS_KEEP_WIDTH, 8, tkeep width (AXIS_DATA_WIDTH/8).
- AXIS_TO_NB_TDEST_WIDTH, 16, tid/tdest width.
- AXIS_TO_NB_TUSER_WIDTH, 16, tuser width.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - i_clk  in  1  clock.
  - i_ap_rst  in  1  asynchronous, active-high reset.
- Source s0, from RPN LAN RX: from_rpn_LAN_RX_{tvalid in 1, tready out 1, tdata in DATA, tkeep in KEEP, tid in TDEST, tdest in TDEST, tuser in TUSER, tlast in 1}.
- Source s1, from RPN LAN TX: from_rpn_LAN_TX_*, same set as s0.
- Source s2, from the initializer: from_rpn_LAN_seq_num_initializer_*, same set as s0.
- Output: to_network_bridge_{tvalid out 1, tready in 1, tdata out, tkeep out, tid out, tdest out, tuser out, tlast out}.
- o_grant  out  3  one-hot current grant; 0 in IDLE.

## Operation
- FSM states:
  - IDLE, after reset.
  - PASS.
- IDLE:
  - Select among sources with tvalid=1.
  - Round-robin: search starts at last_grant+1 mod 3.
  - last_grant resets to 2, so the first search order is s0, s1, s2.
  - When any tvalid is set, register the one-hot grant, update last_grant, and go to PASS.
  - No tready is asserted in IDLE.
- PASS:
  - Granted source tready = (buf_count < 2). Ungranted sources tready = 0.
  - An accepted beat (tvalid && tready) is written into the output buffer with all sideband fields unchanged.
  - Accepting a beat with tlast=1 returns the FSM to IDLE and clears o_grant.
- A granted source that drops tvalid mid-packet keeps the grant. The arbiter waits indefinitely with no timeout.
- Output buffer:
  - 2-entry FIFO; buf_count ranges 0..2.
  - to_network_bridge_tvalid = (buf_count != 0).
  - Head pops on tvalid && tready.
  - A push and a pop in the same cycle leave buf_count unchanged.
- Single-beat packets (tlast on the first beat) are legal.
- The arbiter does not inspect or modify packet content.

## Timing
- Reset values:
  - All tready = 0.
  - to_network_bridge_tvalid = 0; all other to_network_bridge_* = 0.
  - o_grant = 0, FSM in IDLE, last_grant = 2, buf_count = 0.
- Reset mid-packet: buffered beats are discarded and the grant is dropped. The partially sent packet is the source's responsibility.
- Latency:
  - tvalid seen in IDLE at cycle 0.
  - Grant registered at the cycle-1 edge; source tready high during cycle 1.
  - First beat visible on to_network_bridge at cycle 2.
- Throughput: 1 beat/cycle within a packet while the bridge keeps tready=1.
- Inter-packet gap:
  - After the tlast beat is accepted there is one IDLE (arbitration) cycle.
  - So there is at most one input-side bubble between packets.
- Backpressure: with to_network_bridge_tready=0, at most 2 beats are accepted, then the source tready drops. Nothing is lost and nothing is duplicated.
- All tready outputs are driven from registers and FSM state only.

## Configuration
- RPN_LAN_ARB_STRICT_PRIO_EN
  - Defined: fixed priority s0 > s1 > s2 in IDLE. ACKs always win, and last_grant is not used.
  - Undefined (default): round-robin as described in Operation.

## Test plan
- Reset, then s1 sends 3 beats (tdata 0xA1..0xA3, tlast on the third) with bridge tready=1:
  - o_grant=3'b010 at cycle 1.
  - Output tvalid at cycles 2–4 with data A1, A2, A3 in order; tlast only on A3.
  - o_grant=0 after the tlast accept.
- All three sources continuously valid with 1-beat packets:
  - Grant order s0, s1, s2, s0, s1, s2.
  - With the macro defined, s0 is granted every time.
- s0 holds a 4-beat packet while s2 is valid: s2 is not granted until the cycle after s0's tlast is accepted, and s2 tready stays 0 throughout.
- Bridge tready=0 during a 5-beat packet:
  - Exactly 2 beats are accepted, then the source tready=0.
  - Releasing tready delivers all 5 beats with no loss or duplication.
- Assert i_ap_rst after beat 2 of a 4-beat packet: tvalid=0 and o_grant=0 immediately (asynchronously), and the next grant order restarts at s0.
- Granted s1 drops tvalid for 3 cycles mid-packet while s0 is valid: the grant is held on s1 and no s0 beat is interleaved.
